// File: rtl/divide_24x12.sv
// Sequential restoring divider for DVI: {AC,MQ} / divisor, one quotient bit per clock.
// Optional macro DIV_OVF_ABORT_EN: on overflow, skip CALC and go straight to DONE.
module divide_24x12 #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               start,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               overflow,
    output logic               finished
);

    localparam int unsigned W = WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Partial remainder: the restoring step keeps it below D, so the top bit of s is never stored.
    logic [W-1:0]       r_q, r_d;
    logic [W-1:0]       q_q, q_d;
    logic [W-1:0]       d_q, d_d;
    logic               ovf_q, ovf_d;
    logic               finished_q;

    logic [W:0]         s_c;
    logic               ge_c;
    logic               ovf_load_c;

    assign s_c        = {r_q, q_q[W-1]};
    assign ge_c       = (s_c >= {1'b0, d_q});
    assign ovf_load_c = (dividend[2*W-1:W] >= divisor);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            ovf_q      <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            q_q        <= q_d;
            d_q        <= d_d;
            ovf_q      <= ovf_d;
            finished_q <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d   = dividend[2*W-1:W];
                    q_d   = dividend[W-1:0];
                    d_d   = divisor;
                    ovf_d = ovf_load_c;
                    cnt_d = '0;
`ifdef DIV_OVF_ABORT_EN
                    state_d = ovf_load_c ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                // On overflow the iterations still run but the loaded operands are kept.
                if (!ovf_q) begin
                    if (ge_c) begin
                        r_d = W'(s_c - {1'b0, d_q});
                        q_d = {q_q[W-2:0], 1'b1};
                    end else begin
                        r_d = W'(s_c);
                        q_d = {q_q[W-2:0], 1'b0};
                    end
                end
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? HOLD : IDLE;
            end
            HOLD: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign overflow  = ovf_q;
    assign finished  = finished_q;

endmodule

// File: tb/tb_divide_24x12.sv
// Self-checking bench for divide_24x12: vector table + scoreboard queue, plus handshake/reset sequences.
module tb_divide_24x12;

    typedef struct {
        logic [23:0] dd;
        logic [11:0] dv;
        logic [11:0] q;
        logic [11:0] r;
        logic        ovf;
    } vec_t;

`ifdef DIV_OVF_ABORT_EN
    localparam int OVF_LAT = 1;
`else
    localparam int OVF_LAT = 13;
`endif
    localparam int NORM_LAT = 13;
    localparam int NVEC     = 12;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] dividend;
    logic [11:0] divisor;
    logic        start;
    logic [11:0] quotient;
    logic [11:0] remainder;
    logic        overflow;
    logic        finished;

    int n_chk  = 0;
    int n_pass = 0;

    vec_t vecs [NVEC];
    vec_t sb_q [$];

    divide_24x12 dut (
        .clock     (clock),
        .reset     (reset),
        .dividend  (dividend),
        .divisor   (divisor),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow),
        .finished  (finished)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t model(input logic [23:0] dd, input logic [11:0] dv);
        vec_t v;
        v.dd = dd;
        v.dv = dv;
        if (dd[23:12] >= dv) begin
            v.q   = dd[11:0];
            v.r   = dd[23:12];
            v.ovf = 1'b1;
        end else begin
            v.q   = 12'(dd / {12'd0, dv});
            v.r   = 12'(dd % {12'd0, dv});
            v.ovf = 1'b0;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start for one load edge, scramble inputs during CALC, then check the result.
    task automatic run_op(input string tag, input vec_t e);
        int   lat;
        bit   seen;
        vec_t got;
        sb_q.push_back(e);
        dividend = e.dd;
        divisor  = e.dv;
        start    = 1'b1;
        lat      = 0;
        seen     = 0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (lat == 1) start = 1'b0;
            if (lat >= 2) begin
                dividend = 24'($urandom);
                divisor  = 12'($urandom);
            end
            if (finished) seen = 1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(e.ovf ? OVF_LAT : NORM_LAT));
        got = sb_q.pop_front();
        chk({tag, "_quotient"},  32'(quotient),  32'(got.q));
        chk({tag, "_remainder"}, 32'(remainder), 32'(got.r));
        chk({tag, "_overflow"},  32'(overflow),  32'(got.ovf));
        tick();
        chk({tag, "_finished_one_cycle"}, 32'(finished), 32'd0);
    endtask

    initial begin
        bit   bad;
        vec_t e;

        vecs[0] = '{24'd1000,   12'd7,     12'd142,   12'd6,     1'b0};
        vecs[1] = '{24'hFFEFFF, 12'hFFF,   12'hFFF,   12'hFFE,   1'b0};
        vecs[2] = '{24'h005123, 12'd5,     12'h123,   12'h005,   1'b1};
        vecs[3] = '{24'h000ABC, 12'd0,     12'hABC,   12'h000,   1'b1};
        vecs[4] = '{24'h000FFF, 12'd1,     12'hFFF,   12'h000,   1'b0};
        vecs[5] = '{24'h000000, 12'd3,     12'h000,   12'h000,   1'b0};
        vecs[6] = '{24'h123456, 12'h123,   12'h456,   12'h123,   1'b1};
        vecs[7] = '{24'h0FFFFF, 12'h100,   12'hFFF,   12'h0FF,   1'b0};
        for (int i = 8; i < NVEC; i++) begin
            logic [11:0] dv;
            logic [23:0] dd;
            dv = 12'($urandom_range(1, 4095));
            dd = {12'($urandom_range(0, 32'(dv) - 1)), 12'($urandom)};
            vecs[i] = model(dd, dv);
        end

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_finished",  32'(finished),  32'd0);
        chk("reset_quotient",  32'(quotient),  32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_overflow",  32'(overflow),  32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Held start: one finished pulse, then parks in HOLD without retriggering.
        dividend = 24'd1000;
        divisor  = 12'd7;
        start    = 1'b1;
        bad      = 0;
        begin
            int lat;
            lat = 0;
            while (!finished && lat < 40) begin
                tick();
                lat++;
                if (lat >= 2) dividend = 24'hFFFFFF;
            end
            chk("hold_latency", 32'(lat), 32'(NORM_LAT));
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (finished) bad = 1;
        end
        chk("hold_no_retrigger", 32'(bad), 32'd0);
        chk("hold_quotient",  32'(quotient),  32'd142);
        chk("hold_remainder", 32'(remainder), 32'd6);
        start = 1'b0;
        bad   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (finished) bad = 1;
        end
        chk("release_no_spurious", 32'(bad), 32'd0);
        chk("release_quotient_stable", 32'(quotient), 32'd142);

        // Reset mid-operation discards the partial result.
        dividend = 24'd1000;
        divisor  = 12'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        chk("midreset_finished",  32'(finished),  32'd0);
        chk("midreset_quotient",  32'(quotient),  32'd0);
        chk("midreset_remainder", 32'(remainder), 32'd0);
        chk("midreset_overflow",  32'(overflow),  32'd0);
        reset = 1'b0;
        tick();
        e = model(24'd1000, 12'd7);
        run_op("after_reset", e);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
